intr_handler_mc: RTL
====================

// Module: intr_handler_mc
// PURPOSE
//  Multi-channel, parametrised interrupt/acknowledge handler. Runs the 7-state eql-driven
//  handshake FSM on one channel at a time, picks the next channel round-robin from an enable
//  mask, and bounds every eql hold loop with a timeout. Sits between NCH comparator channels
//  (eql[]) and the shared counter/mux datapath (cc_mux, enable_count, uscite).
// PARAMETERS
//  NCH      4   number of eql channels, >=2
//  CNT_W    4   width of hold-loop timeout counter
//  TIMEOUT  10  cycles a hold state may self-loop before forced exit, 2..2**CNT_W-1
// PORTS
//  clock         in   1               rising-edge clock
//  reset         in   1               asynchronous reset, active-low
//  eql           in   NCH             per-channel equality flag
//  ch_en         in   NCH             channel enable mask for arbitration
//  cont_eql      in   1               counter-equal flag, drives default ack/enable
//  cc_mux        out  2               counter mux select
//  uscite        out  2               output code
//  enable_count  out  1               counter enable
//  ackout        out  1               acknowledge
//  sel_ch        out  $clog2(NCH)     channel currently served
//  timeout       out  1               1-cycle pulse on forced hold-loop exit
// BEHAVIOUR
//  - All outputs registered; they change one clock after the inputs that cause them.
//  - Reset (reset=0, async): state=INIT(000), cc_mux=00, uscite=00, enable_count=0, ackout=0,
//    sel_ch=0, timeout=0, cnt=0. Deassertion is sampled at the next clock edge.
//  - e = eql[sel_ch]. Default each cycle: ackout=enable_count=~cont_eql, timeout=0.
//  - FSM, with next state/cc_mux/uscite:
//    INIT(000):  ->WAIT(001), cc_mux=01, uscite=01.
//    WAIT(001):  e=1 ->ENIN(010), 11/00.  e=0 ->INTR1(101), 10/01.
//    INTR1(101): e=1 ->INTR(100), 11/00.  e=0 ->WAIT, 01/01, advance sel_ch.
//    ENIN(010):  e=1 stay, 11/00.  e=0 ->ENINW(011), 01/01, ackout=enable_count=1 (override).
//    ENINW(011): e=1 stay, 01/01.  e=0 ->WAIT, 01/01, advance sel_ch.
//    INTR(100):  e=1 stay, 11/00.  e=0 ->INTRW(110), 10/11.
//    INTRW(110): e=1 stay, 10/11.  e=0 ->WAIT, 01/01, advance sel_ch.
//    Unused 111: ->INIT next cycle with reset output values.
//  - Hold states are 010, 011, 100 and 110. cnt clears on every state change.
//    cnt increments on each self-loop cycle. If a self-loop is taken while cnt==TIMEOUT-1:
//    go to WAIT, cc_mux=01, uscite=01, timeout=1, cnt=0, advance sel_ch.
//    This forced exit has priority over e.
//  - Advance sel_ch: next index after sel_ch, modulo NCH, with ch_en bit set.
//    If no bit is set, sel_ch holds. If only the current bit is set, sel_ch holds.
//  - ch_en changes never abort a channel in service; they only affect the next advance.
//  - eql of channels other than sel_ch is ignored.
//  - Async reset mid-sequence returns to INIT immediately. No partial output is retained.
// TESTING
//  1 reset=0 for 2 cycles then release, eql=0 -> cycle1 state 001, cc_mux=01, uscite=01;
//    all resets then read zero.
//  2 ch_en=1111, cont_eql=0, eql[0]: 1,1,0,0 from WAIT -> states 010,010,011,001;
//    ackout=1 throughout; sel_ch 0->1 on last step.
//  3 eql[1]: 0,1,0,0 from WAIT -> states 101,100,110,001;
//    uscite 01,00,11,01; cc_mux 10,11,10,01.
//  4 Hold eql[sel_ch]=1 in ENIN with TIMEOUT=10 -> exit to WAIT after 10 self-loops;
//    timeout=1 for exactly 1 cycle; cnt=0.
//  5 ch_en=0101, sel_ch=0, return to WAIT -> sel_ch=2, then 0.
//    ch_en=0000 -> sel_ch frozen.
//  6 Drop reset while in INTRW with eql=1 -> all outputs zero asynchronously;
//    state INIT; FSM restarts at 001 one cycle after release.

Source files
------------

// File: rtl/intr_handler_mc.sv
// Multi-channel eql-driven interrupt/acknowledge FSM with round-robin channel selection and
// bounded hold loops. All outputs registered (one-cycle latency); no backpressure, one channel served at a time.
module intr_handler_mc #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCH-1:0]           eql,
  input  logic [NCH-1:0]           ch_en,
  input  logic                     cont_eql,
  output logic [1:0]               cc_mux,
  output logic [1:0]               uscite,
  output logic                     enable_count,
  output logic                     ackout,
  output logic [$clog2(NCH)-1:0]   sel_ch,
  output logic                     timeout
);

  localparam int SW = $clog2(NCH);

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    WAIT   = 3'b001,
    ENIN   = 3'b010,
    ENINW  = 3'b011,
    INTR   = 3'b100,
    INTR1  = 3'b101,
    INTRW  = 3'b110,
    UNUSED = 3'b111
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cc_mux_q, cc_mux_d;
  logic [1:0]       uscite_q, uscite_d;
  logic             enable_count_q, enable_count_d;
  logic             ackout_q, ackout_d;
  logic [SW-1:0]    sel_ch_q, sel_ch_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             e;
  logic             stay;
  logic             adv;
  logic             found;
  logic [SW-1:0]    next_ch;
  logic [SW-1:0]    idx_s;

  assign e = eql[sel_ch_q];

  // Next enabled channel after the current one; holds when none other is enabled.
  always_comb begin
    found   = 1'b0;
    next_ch = sel_ch_q;
    idx_s   = '0;
    for (int i = 1; i < NCH; i++) begin
      idx_s = SW'((int'(sel_ch_q) + i) % NCH);
      if (!found && ch_en[idx_s]) begin
        found   = 1'b1;
        next_ch = idx_s;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cc_mux_d       = cc_mux_q;
    uscite_d       = uscite_q;
    ackout_d       = ~cont_eql;
    enable_count_d = ~cont_eql;
    timeout_d      = 1'b0;
    sel_ch_d       = sel_ch_q;
    cnt_d          = '0;
    stay           = 1'b0;
    adv            = 1'b0;

    case (state_q)
      INIT: begin
        state_d = WAIT; cc_mux_d = 2'b01; uscite_d = 2'b01;
      end
      WAIT: begin
        if (e) begin state_d = ENIN;  cc_mux_d = 2'b11; uscite_d = 2'b00; end
        else   begin state_d = INTR1; cc_mux_d = 2'b10; uscite_d = 2'b01; end
      end
      INTR1: begin
        if (e) begin state_d = INTR; cc_mux_d = 2'b11; uscite_d = 2'b00; end
        else   begin state_d = WAIT; cc_mux_d = 2'b01; uscite_d = 2'b01; adv = 1'b1; end
      end
      ENIN: begin
        if (e) begin stay = 1'b1; cc_mux_d = 2'b11; uscite_d = 2'b00; end
        else begin
          state_d = ENINW; cc_mux_d = 2'b01; uscite_d = 2'b01;
          ackout_d = 1'b1; enable_count_d = 1'b1;
        end
      end
      ENINW: begin
        if (e) begin stay = 1'b1; cc_mux_d = 2'b01; uscite_d = 2'b01; end
        else   begin state_d = WAIT; cc_mux_d = 2'b01; uscite_d = 2'b01; adv = 1'b1; end
      end
      INTR: begin
        if (e) begin stay = 1'b1; cc_mux_d = 2'b11; uscite_d = 2'b00; end
        else   begin state_d = INTRW; cc_mux_d = 2'b10; uscite_d = 2'b11; end
      end
      INTRW: begin
        if (e) begin stay = 1'b1; cc_mux_d = 2'b10; uscite_d = 2'b11; end
        else   begin state_d = WAIT; cc_mux_d = 2'b01; uscite_d = 2'b01; adv = 1'b1; end
      end
      default: begin
        state_d = INIT; cc_mux_d = 2'b00; uscite_d = 2'b00;
        ackout_d = 1'b0; enable_count_d = 1'b0; sel_ch_d = '0;
      end
    endcase

    // A self-loop reaching the limit is turned into a forced return to WAIT.
    if (stay) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d   = WAIT; cc_mux_d = 2'b01; uscite_d = 2'b01;
        timeout_d = 1'b1; adv = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (adv) sel_ch_d = next_ch;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= INIT;
      cc_mux_q       <= 2'b00;
      uscite_q       <= 2'b00;
      enable_count_q <= 1'b0;
      ackout_q       <= 1'b0;
      sel_ch_q       <= '0;
      timeout_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      cc_mux_q       <= cc_mux_d;
      uscite_q       <= uscite_d;
      enable_count_q <= enable_count_d;
      ackout_q       <= ackout_d;
      sel_ch_q       <= sel_ch_d;
      timeout_q      <= timeout_d;
      cnt_q          <= cnt_d;
    end
  end

  assign cc_mux       = cc_mux_q;
  assign uscite       = uscite_q;
  assign enable_count = enable_count_q;
  assign ackout       = ackout_q;
  assign sel_ch       = sel_ch_q;
  assign timeout      = timeout_q;

endmodule
